// File: rtl/alu_pkg.sv
// Shared definitions for the operand sequencer: sequencer state codes and
// the default button debounce interval (10 ms at 100 MHz).
package alu_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_SHOW   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and rising
// edge detect. The debounced level only moves after the synchronized input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; a single
// agreeing cycle restarts the count. press is a one-cycle pulse issued on the
// same edge the level goes 0->1.
module button_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so it can never wrap early.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Count consecutive disagreeing cycles; flip the level at the threshold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_q;
        press <= sync_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Operand sequencer: steps through operand A, operand B + opcode capture,
// a single-cycle execute strobe and a result-show phase, driven by a
// debounced go button. A debounced clear button returns to S_LOAD_A and
// zeroes the latched operands from any state, and wins over a simultaneous go.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_LOAD_A | waiting for go; go captures data_in into a_out
//   S_LOAD_B | waiting for go; go captures data_in into b_out, op_sel into op_out
//   S_EXEC   | one cycle; raises exec_pulse on leaving, go ignored
//   S_SHOW   | result displayed; go returns to S_LOAD_A
module operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_go_raw,
  input  logic       btn_clr_raw,
  input  logic [7:0] data_in,
  input  logic [3:0] op_sel,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [3:0] op_out,
  output logic       exec_pulse,
  output logic [1:0] phase
);

  seq_state_t state, state_nxt;
  logic [7:0] a_nxt, b_nxt;
  logic [3:0] op_nxt;
  logic       exec_nxt;

  logic go_press, clr_press;
  logic go_level, clr_level;

  // Debounced levels are not needed by the sequencer, only the press events.
  logic unused_levels;
  assign unused_levels = go_level ^ clr_level;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_btn (
    .clock (clock),
    .reset (reset),
    .raw   (btn_go_raw),
    .level (go_level),
    .press (go_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_btn (
    .clock (clock),
    .reset (reset),
    .raw   (btn_clr_raw),
    .level (clr_level),
    .press (clr_press)
  );

  // Next state and next register values; clear has priority over everything.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_out;
    b_nxt     = b_out;
    op_nxt    = op_out;
    exec_nxt  = 1'b0;
    if (clr_press) begin
      state_nxt = S_LOAD_A;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
    end else begin
      unique case (state)
        S_LOAD_A: begin
          if (go_press) begin
            a_nxt     = data_in;
            state_nxt = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (go_press) begin
            b_nxt     = data_in;
            op_nxt    = op_sel;
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          exec_nxt  = 1'b1;
          state_nxt = S_SHOW;
        end
        S_SHOW: begin
          if (go_press) state_nxt = S_LOAD_A;
        end
        default: state_nxt = S_LOAD_A;
      endcase
    end
  end

  // State and all outputs are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_LOAD_A;
      a_out      <= '0;
      b_out      <= '0;
      op_out     <= '0;
      exec_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      a_out      <= a_nxt;
      b_out      <= b_nxt;
      op_out     <= op_nxt;
      exec_pulse <= exec_nxt;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer with a short debounce interval. A behavioural
// model tracks raw button history, derives press events from run lengths of
// stable samples and applies the sequencing rules; outputs are compared
// against it every cycle, with directed literal checks along the way.
module tb_operand_sequencer;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_go_raw = 1'b0;
  logic       btn_clr_raw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] op_sel = 4'h0;
  logic [7:0] a_out, b_out;
  logic [3:0] op_out;
  logic       exec_pulse;
  logic [1:0] phase;

  int checks = 0;
  int failures = 0;
  int exec_cnt = 0;

  operand_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_go_raw  (btn_go_raw),
    .btn_clr_raw (btn_clr_raw),
    .data_in     (data_in),
    .op_sel      (op_sel),
    .a_out       (a_out),
    .b_out       (b_out),
    .op_out      (op_out),
    .exec_pulse  (exec_pulse),
    .phase       (phase)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Button i: 0 = go, 1 = clear. hist[i][0] is the raw value sampled one
  // edge ago, hist[i][1] two edges ago (what the debouncer sees now).
  logic [1:0] hist [2];
  logic       m_lvl [2];
  int         m_run [2];
  logic       m_ev  [2];
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [3:0] m_op = 4'h0;
  int         m_ph = 0;
  logic       m_exec = 1'b0;

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      hist[i] = 2'b00; m_lvl[i] = 1'b0; m_run[i] = 0; m_ev[i] = 1'b0;
    end
    m_a = 8'h00; m_b = 8'h00; m_op = 4'h0; m_ph = 0; m_exec = 1'b0;
  endtask

  task automatic m_step();
    logic raw_now [2];
    logic seen;
    raw_now[0] = btn_go_raw;
    raw_now[1] = btn_clr_raw;
    m_exec = 1'b0;
    if (m_ev[1]) begin
      m_a = 8'h00; m_b = 8'h00; m_op = 4'h0; m_ph = 0;
    end else begin
      case (m_ph)
        0: if (m_ev[0]) begin m_a = data_in; m_ph = 1; end
        1: if (m_ev[0]) begin m_b = data_in; m_op = op_sel; m_ph = 2; end
        2: begin m_exec = 1'b1; m_ph = 3; end
        default: if (m_ev[0]) m_ph = 0;
      endcase
    end
    for (int i = 0; i < 2; i++) begin
      seen = hist[i][1];
      m_ev[i] = 1'b0;
      if (seen != m_lvl[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DB) begin
          m_lvl[i] = seen;
          m_run[i] = 0;
          m_ev[i]  = seen;
        end
      end else begin
        m_run[i] = 0;
      end
      hist[i] = {hist[i][0], raw_now[i]};
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic prev_exec;
    prev_exec = 1'b0;
    forever begin
      @(negedge clock);
      checks++;
      if (a_out !== m_a || b_out !== m_b || op_out !== m_op ||
          phase !== 2'(m_ph) || exec_pulse !== m_exec) begin
        failures++;
        $display("FAIL cycle_model t=%0t actual a=%h b=%h op=%h ph=%0d ex=%b required a=%h b=%h op=%h ph=%0d ex=%b",
                 $time, a_out, b_out, op_out, phase, exec_pulse, m_a, m_b, m_op, m_ph, m_exec);
      end
      checks++;
      if (exec_pulse === 1'b1 && prev_exec === 1'b1) begin
        failures++;
        $display("FAIL exec_back_to_back t=%0t actual=11 required=not 11", $time);
      end
      if (exec_pulse === 1'b1) exec_cnt++;
      prev_exec = exec_pulse;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic go, input logic clr, input int hold);
    btn_go_raw = go;
    btn_clr_raw = clr;
    tick(hold);
    btn_go_raw = 1'b0;
    btn_clr_raw = 1'b0;
    tick(DB + 4);
  endtask

  initial begin : stim
    int base_exec;
    bit seen_exec;
    // reset state
    tick(3);
    chk("rst_a", 32'(a_out), 0);
    chk("rst_b", 32'(b_out), 0);
    chk("rst_op", 32'(op_out), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_exec", 32'(exec_pulse), 0);
    reset = 1'b1;
    tick(2);

    // first press latency: a_out moves exactly DB+3 edges after raw rise
    data_in = 8'h3C;
    btn_go_raw = 1'b1;
    repeat (DB + 2) @(posedge clock);
    @(negedge clock);
    chk("lat_a_before", 32'(a_out), 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat_a_at", 32'(a_out), 32'h3C);
    chk("lat_phase", 32'(phase), 1);
    tick(3);
    btn_go_raw = 1'b0;
    tick(DB + 4);
    chk("lat_no_exec", 32'(exec_cnt), 0);

    // operand B and opcode, then execute strobe
    data_in = 8'h34; op_sel = 4'h5;
    press(1'b1, 1'b0, 8);
    chk("seq_b", 32'(b_out), 32'h34);
    chk("seq_op", 32'(op_out), 32'h5);
    chk("seq_phase_show", 32'(phase), 3);
    chk("seq_exec_once", 32'(exec_cnt), 1);

    // long hold in S_SHOW: one transition, a_out retained
    data_in = 8'h99;
    press(1'b1, 1'b0, 50);
    chk("show_hold_phase", 32'(phase), 0);
    chk("show_hold_a", 32'(a_out), 32'h3C);

    data_in = 8'h12;
    press(1'b1, 1'b0, 8);
    chk("a_12", 32'(a_out), 32'h12);
    chk("a_12_phase", 32'(phase), 1);

    // bounce: toggling every 2 cycles never settles
    data_in = 8'h77; op_sel = 4'h9;
    for (int i = 0; i < 10; i++) begin
      btn_go_raw = ~btn_go_raw;
      tick(2);
    end
    btn_go_raw = 1'b0;
    tick(DB + 4);
    chk("bounce_phase", 32'(phase), 1);
    chk("bounce_b", 32'(b_out), 32'h34);
    press(1'b1, 1'b0, 6);
    chk("bounce_then_hold_b", 32'(b_out), 32'h77);
    chk("bounce_then_hold_phase", 32'(phase), 3);
    chk("bounce_exec_cnt", 32'(exec_cnt), 2);

    // go and clear together in S_LOAD_B: clear wins
    press(1'b1, 1'b0, 8);
    data_in = 8'h5A;
    press(1'b1, 1'b0, 8);
    chk("pre_both_phase", 32'(phase), 1);
    base_exec = exec_cnt;
    data_in = 8'hA5; op_sel = 4'hC;
    press(1'b1, 1'b1, 8);
    chk("both_a", 32'(a_out), 0);
    chk("both_b", 32'(b_out), 0);
    chk("both_op", 32'(op_out), 0);
    chk("both_phase", 32'(phase), 0);
    chk("both_no_exec", 32'(exec_cnt), 32'(base_exec));

    // randomized button activity with changing switches
    for (int it = 0; it < 60; it++) begin
      int mode, hold, gap;
      mode = $urandom_range(0, 9);
      hold = $urandom_range(1, 10);
      gap  = $urandom_range(0, 9);
      btn_go_raw  = (mode <= 5) || (mode == 7);
      btn_clr_raw = (mode == 6) || (mode == 7);
      for (int c = 0; c < hold; c++) begin
        data_in = 8'($urandom); op_sel = 4'($urandom);
        tick(1);
      end
      btn_go_raw = 1'b0; btn_clr_raw = 1'b0;
      for (int c = 0; c < gap; c++) begin
        data_in = 8'($urandom); op_sel = 4'($urandom);
        tick(1);
      end
    end
    tick(DB + 4);

    // reset during S_EXEC, go held through reset release
    press(1'b0, 1'b1, 8);
    data_in = 8'h21;
    press(1'b1, 1'b0, 8);
    chk("pre_exec_phase", 32'(phase), 1);
    base_exec = exec_cnt;
    data_in = 8'h66; op_sel = 4'h3;
    btn_go_raw = 1'b1;
    seen_exec = 1'b0;
    for (int c = 0; c < 30 && !seen_exec; c++) begin
      @(negedge clock);
      if (phase == 2'd2) seen_exec = 1'b1;
    end
    chk("reach_exec", 32'(seen_exec), 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_exec_a", 32'(a_out), 0);
    chk("rst_exec_b", 32'(b_out), 0);
    chk("rst_exec_op", 32'(op_out), 0);
    chk("rst_exec_phase", 32'(phase), 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick(10);
    btn_go_raw = 1'b0;
    tick(DB + 4);
    chk("rst_exec_no_pulse", 32'(exec_cnt), 32'(base_exec));
    chk("held_through_rst_phase", 32'(phase), 1);
    chk("held_through_rst_a", 32'(a_out), 32'h66);

    // reset in the middle of a debounce count
    btn_go_raw = 1'b1;
    tick(3);
    reset = 1'b0;
    btn_go_raw = 1'b0;
    #1;
    chk("rst_mid_deb_phase", 32'(phase), 0);
    chk("rst_mid_deb_a", 32'(a_out), 0);
    tick(2);
    reset = 1'b1;
    tick(12);
    chk("mid_deb_no_event_phase", 32'(phase), 0);
    chk("mid_deb_no_event_a", 32'(a_out), 0);
    chk("mid_deb_no_exec", 32'(exec_cnt), 32'(base_exec));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable cycles (10 ms at 100 MHz) before a button level is accepted; legal range 2..2^24-1.
REQ-002 clock  input  1  single system clock; all state rising-edge triggered.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 btn_go_raw  input  1  raw, unsynchronized step/execute pushbutton.
REQ-005 btn_clr_raw  input  1  raw, unsynchronized clear pushbutton.
REQ-006 data_in  input  8  operand value from switches.
REQ-007 op_sel  input  4  operation code from switches.
REQ-008 a_out  output  8  latched operand A, registered.
REQ-009 b_out  output  8  latched operand B, registered.
REQ-010 op_out  output  4  latched operation code, registered.
REQ-011 exec_pulse  output  1  single-cycle execute strobe to the ALU stage, registered.
REQ-012 phase  output  2  current FSM state encoding for LED/display status, registered.

Function
REQ-013 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; one cycle of agreement resets the counter to 0.
REQ-015 A press event SHALL be a one-cycle pulse on each debounced 0->1 transition; release generates no event; a held button generates exactly one event.
REQ-016 Latency raw-rise (held stable) to registered effect on outputs SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-017 FSM states: S_LOAD_A=0, S_LOAD_B=1, S_EXEC=2, S_SHOW=3; phase SHALL equal the state code.
REQ-018 S_LOAD_A + go event: a_out <= data_in, next S_LOAD_B.
REQ-019 S_LOAD_B + go event: b_out <= data_in, op_out <= op_sel (same edge), next S_EXEC.
REQ-020 S_EXEC: unconditional, lasts exactly one cycle, exec_pulse=1 in the cycle following entry, next S_SHOW; go events in S_EXEC SHALL be ignored.
REQ-021 S_SHOW + go event: next S_LOAD_A; a_out, b_out, op_out retain values until overwritten.
REQ-022 Clear event in any state: a_out, b_out, op_out <= 0, next S_LOAD_A, no exec_pulse.
REQ-023 Clear and go events in the same cycle: clear SHALL win; go is discarded.
REQ-024 Clear event while in S_EXEC SHALL suppress that cycle's exec_pulse.
REQ-025 exec_pulse SHALL never be high for two consecutive cycles.
REQ-026 data_in/op_sel changes outside a capturing edge SHALL not affect any output.

Reset
REQ-027 On reset=0: state S_LOAD_A, a_out=0, b_out=0, op_out=0, exec_pulse=0, phase=0, synchronizers/debounced levels/counters =0, asynchronously.
REQ-028 A button held through reset release SHALL produce one go event after the debounce interval (debounced level starts at 0).
REQ-029 Reset asserted mid-debounce or mid-S_EXEC SHALL abort with no pulse emitted.

Structure
REQ-030 Shared package/include alu_pkg SHALL hold the state encodings and the DEBOUNCE_CYCLES default.
REQ-031 Synchronizer, counter and edge detect SHALL form sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clock, reset, raw, level, press), instantiated twice.
REQ-032 Counter width SHALL be derived from DEBOUNCE_CYCLES; no wrap-around permitted before the threshold.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset, data_in=0x3C, go held 10 cycles -> a_out=0x3C exactly 7 cycles after rise, phase=1, exec_pulse stays 0.
REQ-034 Full sequence A=0x12, B=0x34 with op_sel=0x5 -> b_out=0x34, op_out=0x5, exactly one exec_pulse, phase 2 then 3.
REQ-035 Go toggled every 2 cycles for 20 cycles (bounce) -> no event, phase unchanged; then held 6 cycles -> one event.
REQ-036 Go and clear raised in the same cycle while in S_LOAD_B -> all outputs 0, phase=0, no exec_pulse.
REQ-037 Go held 50 cycles in S_SHOW -> single transition to S_LOAD_A, a_out unchanged until next press.
REQ-038 reset=0 pulsed during S_EXEC and during a debounce count -> outputs 0 immediately, no exec_pulse afterwards.
